// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory request controller.
package dmem_pkg;

    localparam int unsigned WORD_DEF = 32;
    localparam int unsigned ADDR_DEF = 16;

    function automatic int unsigned be_width(input int unsigned word);
        return word / 8;
    endfunction

    localparam int unsigned BE_W_DEF = be_width(WORD_DEF);
    localparam logic [BE_W_DEF-1:0] BE_FULL = '1;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        MERGE
    } state_t;

endpackage

// File: rtl/byte_merge.sv
// Combinational byte-lane merge: strobed bytes come from new_word, the rest from old_word.
module byte_merge
    import dmem_pkg::*;
#(
    parameter  int unsigned WORD = WORD_DEF,
    localparam int unsigned BE_W = WORD / 8
) (
    input  logic [WORD-1:0] old_word,
    input  logic [WORD-1:0] new_word,
    input  logic [BE_W-1:0] be,
    output logic [WORD-1:0] merged
);

    always_comb begin
        merged = old_word;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Load/store front end for a single-port memory without byte enables;
// partial stores are turned into a read followed by a merged write.
module dmem_rmw_ctrl
    import dmem_pkg::*;
#(
    parameter  int unsigned WORD = WORD_DEF,
    parameter  int unsigned ADDR = ADDR_DEF,
    localparam int unsigned BE_W = WORD / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [BE_W-1:0] req_be,
    input  logic [ADDR-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [WORD-1:0] rsp_rdata,
    output logic [ADDR-1:0] mem_A,
    output logic            mem_W,
    output logic [WORD-1:0] mem_D,
    input  logic [WORD-1:0] mem_Q
);

    state_t          state;
    logic [ADDR-1:0] lat_addr;
    logic [BE_W-1:0] lat_be;
    logic [WORD-1:0] lat_wdata;
    logic [WORD-1:0] merged;
    logic            accept;
    logic            is_full;
    logic            is_partial;

    assign accept     = req_valid && req_ready;
    assign is_full    = &req_be;
    assign is_partial = (|req_be) && !is_full;

    byte_merge #(.WORD(WORD)) u_byte_merge (
        .old_word (mem_Q),
        .new_word (lat_wdata),
        .be       (lat_be),
        .merged   (merged)
    );

    // Outputs are gated by rst directly so a reset landing in MERGE never writes.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        mem_A     = req_addr;
        mem_D     = req_wdata;
        mem_W     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE, RD_WAIT: begin
                    req_ready = 1'b1;
                    mem_W     = req_valid && req_we && is_full;
                    if (state == RD_WAIT) begin
                        rsp_valid = 1'b1;
                        rsp_rdata = mem_Q;
                    end
                end
                MERGE: begin
                    mem_A = lat_addr;
                    mem_D = merged;
                    mem_W = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, RD_WAIT: begin
                    state <= IDLE;
                    if (accept) begin
                        if (!req_we) begin
                            state <= RD_WAIT;
                        end else if (is_partial) begin
                            state     <= MERGE;
                            lat_addr  <= req_addr;
                            lat_be    <= req_be;
                            lat_wdata <= req_wdata;
                        end
                    end
                end
                MERGE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Scoreboard bench: behavioural memory plus reference image, directed cases then random traffic.
module tb_dmem_rmw_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = '0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [15:0] mem_A;
    logic        mem_W;
    logic [31:0] mem_D;
    logic [31:0] mem_Q;

    always #5 clk = ~clk;

    dmem_rmw_ctrl #(.WORD(32), .ADDR(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_A     (mem_A),
        .mem_W     (mem_W),
        .mem_D     (mem_D),
        .mem_Q     (mem_Q)
    );

    typedef struct packed {
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    function automatic logic [31:0] init_val(input int unsigned a);
        case (a)
            32'h20:  return 32'h11223344;
            32'h30:  return 32'h55555555;
            32'h40:  return 32'h01020304;
            default: return (a * 32'h9E3779B1) ^ 32'hA5A50000;
        endcase
    endfunction

    // Single-port memory: registered read, Q holds during writes.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_W) mem[mem_A] = mem_D;
            else       mem_Q <= mem[mem_A];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
            chk("rst_mem_W", {31'd0, mem_W}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_rdata", rsp_rdata, exp_q[0].data);
            void'(exp_q.pop_front());
        end else begin
            chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("idle_rsp_rdata", rsp_rdata, 32'd0);
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                chk("rsp_missing", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1. commit=0 leaves a partial store in MERGE.
    task automatic issue(input logic we, input logic [3:0] be, input logic [15:0] addr,
                         input logic [31:0] wd, input bit commit);
        int unsigned n = 0;
        logic [31:0] merged;
        bit          partial;
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wd;
        #1;
        while (!req_ready) begin
            if (n == 20) begin
                chk("ready_timeout", 32'd0, 32'd1);
                req_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #2;
            n++;
        end
        chk("acc_mem_A", {16'd0, mem_A}, {16'd0, addr});
        chk("acc_mem_W", {31'd0, mem_W}, {31'd0, (we && be == BE_FULL)});
        merged = ref_mem[addr];
        for (int i = 0; i < 4; i++) if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
        partial = we && be != 4'h0 && be != BE_FULL;
        if (!we) exp_q.push_back('{data: ref_mem[addr], due: cyc + 1});
        else if (commit && be != 4'h0) ref_mem[addr] = merged;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (partial && commit) begin
            #1;
            chk("merge_req_ready", {31'd0, req_ready}, 32'd0);
            chk("merge_mem_W", {31'd0, mem_W}, 32'd1);
            chk("merge_mem_A", {16'd0, mem_A}, {16'd0, addr});
            chk("merge_mem_D", mem_D, merged);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("idle_mem_W", {31'd0, mem_W}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  be;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);

        // Reset with a request pending.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_be    = 4'hF;
        req_addr  = 16'h0010;
        req_wdata = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Full store then load.
        issue(1'b1, 4'hF, 16'h0010, 32'hDEADBEEF, 1'b1);
        issue(1'b0, 4'h0, 16'h0010, 32'h0, 1'b1);
        idle(2);

        // Partial store read-modify-write.
        issue(1'b1, 4'b0101, 16'h0020, 32'hAABBCCDD, 1'b1);
        chk("partial_image", ref_mem[16'h0020], 32'h11BB33DD);
        issue(1'b0, 4'h0, 16'h0020, 32'h0, 1'b1);
        idle(2);

        // Back-to-back loads.
        issue(1'b0, 4'h0, 16'h0001, 32'h0, 1'b1);
        issue(1'b0, 4'h0, 16'h0002, 32'h0, 1'b1);
        issue(1'b0, 4'h0, 16'h0003, 32'h0, 1'b1);
        idle(2);

        // Zero-strobe store is a no-op.
        issue(1'b1, 4'h0, 16'h0030, 32'h12345678, 1'b1);
        idle(1);
        issue(1'b0, 4'h0, 16'h0030, 32'h0, 1'b1);
        idle(2);

        // Reset while in MERGE abandons the write.
        issue(1'b1, 4'b1000, 16'h0040, 32'hFFEEDDCC, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_merge_mem_W", {31'd0, mem_W}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_rst2", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        issue(1'b0, 4'h0, 16'h0040, 32'h0, 1'b1);
        chk("abandoned_image", ref_mem[16'h0040], 32'h01020304);
        idle(2);

        // Random traffic over a small address window to force reuse.
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0:       be = 4'h0;
                1:       be = 4'hF;
                default: be = 4'($urandom);
            endcase
            a = 16'($urandom_range(0, 15));
            issue(1'($urandom_range(0, 1)), be, a, $urandom, 1'b1);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(4);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
